// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl: byte-serial command sequencer driving the register-file port and returning read data to TX.
// Optional: define REG_CTRL_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle cycles.
module reg_file_ctrl #(
  parameter int DATAWIDTH = 8,
  parameter int ADDR = 4,
  parameter logic [DATAWIDTH-1:0] WR_CMD = 8'hAA,
  parameter logic [DATAWIDTH-1:0] RD_CMD = 8'hBB,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATAWIDTH-1:0] RX_P_DATA,
  input  logic                 RX_D_VLD,
  output logic [ADDR-1:0]      Address,
  output logic                 WrEn,
  output logic                 RdEn,
  output logic [DATAWIDTH-1:0] WrData,
  input  logic [DATAWIDTH-1:0] RdData,
  input  logic                 RdData_Valid,
  output logic [DATAWIDTH-1:0] TX_P_DATA,
  output logic                 TX_D_VLD,
  input  logic                 TX_Busy,
  output logic                 Cmd_Err
);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND} state_t;

  state_t     state;
  logic [2:0] wait_cnt;

`ifdef REG_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] to_cnt;
  logic          in_frame;
  logic          to_hit;
  assign in_frame = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR);
  assign to_hit   = in_frame && !RX_D_VLD && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  // Frame parser, strobe generation, read-response wait and TX handshake; all outputs registered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      Address   <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      Cmd_Err   <= 1'b0;
`ifdef REG_CTRL_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      TX_D_VLD <= 1'b0;
      Cmd_Err  <= 1'b0;
      case (state)
        IDLE:
          if (RX_D_VLD) begin
            if (RX_P_DATA == WR_CMD) state <= WR_ADDR;
            else if (RX_P_DATA == RD_CMD) state <= RD_ADDR;
            else Cmd_Err <= 1'b1;
          end
        WR_ADDR:
          if (RX_D_VLD) begin
            Address <= RX_P_DATA[ADDR-1:0];
            state   <= WR_DATA;
          end
        WR_DATA:
          if (RX_D_VLD) begin
            WrData <= RX_P_DATA;
            WrEn   <= 1'b1;
            state  <= IDLE;
          end
        RD_ADDR:
          if (RX_D_VLD) begin
            Address  <= RX_P_DATA[ADDR-1:0];
            RdEn     <= 1'b1;
            wait_cnt <= '0;
            state    <= RD_WAIT;
          end
        // First RD_WAIT cycle is the RdEn cycle; give up after four more without a response.
        RD_WAIT:
          if (RdData_Valid) begin
            TX_P_DATA <= RdData;
            state     <= TX_SEND;
          end else if (wait_cnt == 3'd4) begin
            Cmd_Err <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        TX_SEND:
          if (!TX_Busy) begin
            TX_D_VLD <= 1'b1;
            state    <= IDLE;
          end
        default: state <= IDLE;
      endcase
`ifdef REG_CTRL_TIMEOUT_EN
      // Every entry into a timed state happens on an RX byte, so clearing on RX_D_VLD also covers entry.
      to_cnt <= (!in_frame || RX_D_VLD || to_hit) ? '0 : to_cnt + 1'b1;
      if (to_hit) begin
        Cmd_Err <= 1'b1;
        state   <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb_reg_file_ctrl: randomized frame-level bench with a register-file model and a frame-level reference.
module tb_reg_file_ctrl;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] RX_P_DATA = '0;
  logic       RX_D_VLD = 1'b0;
  logic [3:0] Address;
  logic       WrEn;
  logic       RdEn;
  logic [7:0] WrData;
  logic [7:0] RdData;
  logic       RdData_Valid;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       TX_Busy = 1'b0;
  logic       Cmd_Err;

  reg_file_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD(TX_D_VLD), .TX_Busy(TX_Busy), .Cmd_Err(Cmd_Err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] rst_val(int i);
    return 8'(i * 17) ^ 8'h3B;
  endfunction

  // Register file environment: one-cycle registered read response, optional stall.
  logic [7:0] rf[16];
  logic       stall = 1'b0;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) rf[i] <= rst_val(i);
      RdData_Valid <= 1'b0;
      RdData <= '0;
    end else begin
      RdData_Valid <= RdEn && !stall;
      if (RdEn) RdData <= rf[Address];
      if (WrEn) rf[Address] <= WrData;
    end
  end

  // Observed transactions, sampled on the falling edge.
  logic [11:0] wr_q[$];
  logic [3:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  int          n_cmd_err;
  int          n_both;
  always @(negedge CLK) begin
    if (RST) begin
      if (WrEn) wr_q.push_back({Address, WrData});
      if (RdEn) rd_q.push_back(Address);
      if (TX_D_VLD) tx_q.push_back(TX_P_DATA);
      if (Cmd_Err) n_cmd_err++;
      if (WrEn && RdEn) n_both++;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] mdl[16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    tick(1);
    RX_D_VLD = 1'b0;
  endtask

  task automatic clr();
    wr_q.delete();
    rd_q.delete();
    tx_q.delete();
    n_cmd_err = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = rst_val(i);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input string tag);
    clr();
    send(8'hAA);
    send(a);
    send(d);
    tick(4);
    mdl[a[3:0]] = d;
    chk({tag, ".wr_n"}, wr_q.size(), 1);
    if (wr_q.size() > 0) chk({tag, ".wr"}, wr_q[0], {a[3:0], d});
    chk({tag, ".rd_n"}, rd_q.size(), 0);
    chk({tag, ".err"}, n_cmd_err, 0);
  endtask

  task automatic do_read(input logic [7:0] a, input int busy, input string tag);
    clr();
    TX_Busy = busy > 0;
    send(8'hBB);
    send(a);
    if (busy > 0) begin
      for (int i = 0; i < busy; i++) begin
        if (i == 4 && busy >= 6) send(8'($urandom));
        else tick(1);
      end
      chk({tag, ".held"}, tx_q.size(), 0);
      TX_Busy = 1'b0;
    end
    tick(4);
    chk({tag, ".tx_n"}, tx_q.size(), 1);
    if (tx_q.size() > 0) chk({tag, ".tx"}, tx_q[0], mdl[a[3:0]]);
    chk({tag, ".rd_n"}, rd_q.size(), 1);
    if (rd_q.size() > 0) chk({tag, ".rd_addr"}, rd_q[0], a[3:0]);
    chk({tag, ".wr_n"}, wr_q.size(), 0);
    chk({tag, ".err"}, n_cmd_err, 0);
  endtask

  task automatic do_bad(input logic [7:0] b, input string tag);
    clr();
    send(b);
    tick(3);
    chk({tag, ".err"}, n_cmd_err, 1);
    chk({tag, ".wr_n"}, wr_q.size(), 0);
    chk({tag, ".rd_n"}, rd_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    model_reset();
    #2 RST = 1'b0;
    tick(3);
    chk("reset.outs", {Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD, Cmd_Err}, '0);
    RST = 1'b1;
    tick(2);

    do_write(8'h05, 8'h3C, "w5");
    do_read(8'h05, 0, "r5");
    do_read(8'h03, 20, "r3_busy");
    do_bad(8'h55, "bad55");
    do_write(8'h1F, 8'h77, "w1f");
    do_read(8'h0F, 0, "rf");

    clr();
    send(8'hAA);
    send(8'h02);
    RST = 1'b0;
    tick(2);
    chk("abort.outs", {Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD, Cmd_Err}, '0);
    RST = 1'b1;
    model_reset();
    tick(1);
    send(8'h11);
    tick(3);
    chk("abort.wr_n", wr_q.size(), 0);
    chk("abort.err", n_cmd_err, 1);

    clr();
    send(8'hAA);
    send(8'h04);
    tick(16);
    chk("to.early", n_cmd_err, 0);
`ifdef REG_CTRL_TIMEOUT_EN
    tick(1);
    chk("to.fire", n_cmd_err, 1);
    send(8'h3C);
    tick(3);
    chk("to.wr_n", wr_q.size(), 0);
    chk("to.err", n_cmd_err, 2);
`else
    tick(8);
    chk("nto.err", n_cmd_err, 0);
    send(8'h3C);
    tick(3);
    mdl[4] = 8'h3C;
    chk("nto.wr_n", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("nto.wr", wr_q[0], 12'h43C);
    chk("nto.err", n_cmd_err, 0);
`endif

    clr();
    stall = 1'b1;
    send(8'hBB);
    send(8'h07);
    tick(8);
    stall = 1'b0;
    chk("stall.rd_n", rd_q.size(), 1);
    chk("stall.err", n_cmd_err, 1);
    chk("stall.tx_n", tx_q.size(), 0);

    for (int k = 0; k < 60; k++) begin
      tick($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: do_write(8'($urandom), 8'($urandom), $sformatf("rnd%0d.w", k));
        1: do_read(8'($urandom), ($urandom_range(0, 1) != 0) ? $urandom_range(1, 9) : 0,
                   $sformatf("rnd%0d.r", k));
        default: begin
          b = 8'($urandom);
          if (b == 8'hAA || b == 8'hBB) b = 8'h55;
          do_bad(b, $sformatf("rnd%0d.bad", k));
        end
      endcase
    end

    chk("never_both", n_both, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_file_ctrl.md
Name: reg_file_ctrl

Overview:
- Command sequencer that owns the register-file port in the system domain.
- Parses byte-serial command frames from the UART RX path and issues single-cycle write or read strobes to the register file.
- Returns read data to the UART TX path through a busy/valid handshake.
- Sits between the RX data synchronizer, the register file and the TX data path; it is the only master of the register-file port.

Parameters:
- DATAWIDTH, 8, width of frame bytes, register data and TX data.
- ADDR, 4, register-file address width; the address is the low ADDR bits of the address byte.
- WR_CMD, 8'hAA, opcode for a write frame (opcode, addr, data).
- RD_CMD, 8'hBB, opcode for a read frame (opcode, addr).
- TIMEOUT_CYCLES, 1024, inter-byte timeout; used only with REG_CTRL_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- RX_P_DATA  in  DATAWIDTH  received frame byte; valid only while RX_D_VLD=1.
- RX_D_VLD  in  1  one-cycle pulse per received byte.
- Address  out  ADDR  register-file address.
- WrEn  out  1  register-file write strobe.
- RdEn  out  1  register-file read strobe.
- WrData  out  DATAWIDTH  register-file write data.
- RdData  in  DATAWIDTH  register-file read data.
- RdData_Valid  in  1  read data valid; registered by the register file one cycle after RdEn.
- TX_P_DATA  out  DATAWIDTH  byte to transmit.
- TX_D_VLD  out  1  one-cycle transmit request.
- TX_Busy  in  1  transmitter busy; no request may be issued while it is 1.
- Cmd_Err  out  1  one-cycle pulse on an unknown opcode or an aborted frame.

Behaviour:
- All outputs are registered. Reset value of every output is 0, and the FSM resets to IDLE.
- Reset asserted mid-frame aborts the frame immediately. No strobe is issued after reset.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE:
  - RX_D_VLD with byte==WR_CMD -> WR_ADDR.
  - RX_D_VLD with byte==RD_CMD -> RD_ADDR.
  - Any other byte -> pulse Cmd_Err for 1 cycle and stay in IDLE.
- WR_ADDR: on RX_D_VLD, latch Address <= byte[ADDR-1:0] -> WR_DATA. Upper address bits are ignored and raise no error.
- WR_DATA: on RX_D_VLD, WrData <= byte and WrEn=1 for exactly one cycle -> IDLE.
  - The write lands in the register file at the edge where WrEn is sampled.
- RD_ADDR: on RX_D_VLD, Address <= byte[ADDR-1:0] and RdEn=1 for exactly one cycle -> RD_WAIT.
- RD_WAIT: on RdData_Valid=1, capture TX_P_DATA <= RdData -> TX_SEND.
  - Nominal latency is 1 cycle after the RdEn cycle.
  - If RdData_Valid is still 0 four cycles after RdEn, pulse Cmd_Err and return to IDLE.
- TX_SEND:
  - While TX_Busy=1, hold TX_P_DATA and wait.
  - In the first cycle with TX_Busy=0, drive TX_D_VLD=1 for one cycle -> IDLE.
  - TX_P_DATA stays stable until the next read capture.
- WrEn and RdEn are never asserted in the same cycle. Each is asserted for exactly one cycle per frame.
- Address stays stable from the latch until the next frame's address byte.
- RX_D_VLD arriving in RD_WAIT or TX_SEND: the byte is dropped without error.
- RX_D_VLD in the same cycle a strobe is issued: the strobe completes, and the byte is handled by the next state only from the following cycle.
- Back-to-back frames: a new opcode is accepted in the cycle after return to IDLE.
- Minimum command turnaround: write frame = 3 RX bytes, read frame = 2 RX bytes plus the TX handshake.

Optional Feature:
- Macro: REG_CTRL_TIMEOUT_EN.
- Defined:
  - A counter of clog2(TIMEOUT_CYCLES) bits runs in WR_ADDR, WR_DATA and RD_ADDR.
  - It clears on every RX_D_VLD and on each state entry.
  - On reaching TIMEOUT_CYCLES-1 without RX_D_VLD: pulse Cmd_Err, return to IDLE, issue no strobe.
- Undefined: no counter is present, and partial frames wait indefinitely.

Test Plan:
- Reset, then AA,05,3C -> one WrEn cycle with Address=5, WrData=0x3C; no RdEn or Cmd_Err.
- After the above, BB,05 with TX_Busy=0 -> RdEn one cycle at Address=5; TX_D_VLD pulse with TX_P_DATA=0x3C within 3 cycles.
- BB,03 with TX_Busy held 1 for 20 cycles -> TX_D_VLD stays 0; single pulse with 0x08 (reset value of reg 3) in the first cycle TX_Busy=0.
- Byte 0x55 in IDLE, then AA,1F,77 -> Cmd_Err one pulse, then write to Address=0xF with data 0x77 (upper bits ignored).
- AA,02 then RST low for 2 cycles, then release and send 11 -> no WrEn; Cmd_Err pulse (0x11 is unknown in IDLE).
- With REG_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16: AA,04, then 16 idle cycles -> Cmd_Err pulse, return to IDLE; a later 3C causes no write.
